line_mem_responder: RTL

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

---
 rtl/mem_pkg.sv | 36 +++
 rtl/req_hold_buf.sv | 57 +++++
 rtl/line_mem_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the cache-line to word-memory responder.
//   - Line/word/address geometry of the cache side and the word memory side.
//   - Controller state encoding.
//   - line_word(): selects one 32-bit word out of a 128-bit line.
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int LINE_BITS = 128;
    localparam int WORD_BITS = 32;
    localparam int BEATS     = 4;
    localparam int ADDR_BITS = 27;
    localparam int MEM_AW    = 25;

    // Line address = byte address with the 16-byte offset stripped.
    localparam int LINE_AW   = ADDR_BITS - 4;
    localparam int BEAT_W    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_RESP
    } state_t;

    // Word k of a line occupies bits [32k+31:32k].
    function automatic logic [WORD_BITS-1:0] line_word(
        input logic [LINE_BITS-1:0] line,
        input logic [BEAT_W-1:0]    idx
    );
        return line[int'(idx) * WORD_BITS +: WORD_BITS];
    endfunction

endpackage

// File: rtl/req_hold_buf.sv
// ---------------------------------------------------------------------------
// req_hold_buf
// One-entry holding register for a cache request that arrives while the
// responder is busy.
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset (clears valid only)
//   push       in   load the entry with push_read/push_addr/push_data
//   push_read  in   request type of the entry being loaded (1=read)
//   push_addr  in   line address of the entry being loaded
//   push_data  in   write line of the entry being loaded
//   pop        in   entry consumed this cycle
//   valid      out  entry holds a request
//   read       out  stored request type
//   addr       out  stored line address
//   data       out  stored write line
//
// A push in the same cycle as a pop wins, so the slot is refilled instead
// of being emptied.
// ---------------------------------------------------------------------------
module req_hold_buf
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic                 push_read,
    input  logic [LINE_AW-1:0]   push_addr,
    input  logic [LINE_BITS-1:0] push_data,
    input  logic                 pop,
    output logic                 valid,
    output logic                 read,
    output logic [LINE_AW-1:0]   addr,
    output logic [LINE_BITS-1:0] data
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    // Payload is only meaningful while valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            read <= push_read;
            addr <= push_addr;
            data <= push_data;
        end
    end

endmodule

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
// Converts 128-bit cache line requests into four 32-bit word beats on a
// simple ready-handshaked word memory, and returns read lines to the cache.
//
// Ports
//   clk             in   sole clock, rising edge
//   rstn            in   asynchronous active-low reset
//   ddr2_enable     in   one-cycle request strobe
//   ddr2_read       in   1 = line read, 0 = line write
//   ddr2_addr       in   byte address, bits [3:0] ignored
//   to_ddr2_data    in   write line, word k at bits [32k+31:32k]
//   ddr2_available  out  one-cycle pulse, ddr2_data holds a new read line
//   ddr2_data       out  last completed read line
//   mem_en          out  word access strobe
//   mem_we          out  1 = write beat, 0 = read beat
//   mem_addr        out  word address {line address, beat}
//   mem_wdata       out  write word
//   mem_rdata       in   read word, one cycle after an accepted read beat
//   mem_ready       in   beat accepted when mem_en & mem_ready
//   req_overflow    out  sticky: a request was dropped
//
// Flow: IDLE dispatches a new or held request; WRITE/READ issue beats 0..3
// advancing only on mem_ready; READ continues into DRAIN to collect the last
// word, then RESP raises ddr2_available on the following cycle.
// ---------------------------------------------------------------------------
module line_mem_responder
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ddr2_enable,
    input  logic                 ddr2_read,
    input  logic [ADDR_BITS-1:0] ddr2_addr,
    input  logic [LINE_BITS-1:0] to_ddr2_data,
    output logic                 ddr2_available,
    output logic [LINE_BITS-1:0] ddr2_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic [WORD_BITS-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 req_overflow
);

    state_t                 state;
    state_t                 next_state;
    logic [BEAT_W-1:0]      beat;

    // Request currently being transferred.
    logic [LINE_AW-1:0]     cur_addr;
    logic [LINE_BITS-1:0]   cur_data;

    // Held request.
    logic                   pend_valid;
    logic                   pend_read;
    logic [LINE_AW-1:0]     pend_addr;
    logic [LINE_BITS-1:0]   pend_data;
    logic                   pend_push;

    // Dispatch decode.
    logic                   in_idle;
    logic                   take_new;
    logic                   take_pend;
    logic                   dispatch;
    logic                   disp_read;
    logic [LINE_AW-1:0]     disp_addr;
    logic [LINE_BITS-1:0]   disp_data;
    logic                   drop;

    // Beat handshake.
    logic                   beat_done;
    logic                   last_beat;

    // Read return path.
    logic                   rd_vld_p1;
    logic [BEAT_W-1:0]      rd_idx_p1;
    logic [WORD_BITS-1:0]   shadow [BEATS-1];

    logic                   unused_addr_lsbs;

    assign unused_addr_lsbs = ^ddr2_addr[3:0];

    // -----------------------------------------------------------------------
    // Request acceptance
    // -----------------------------------------------------------------------
    // In IDLE a held request always goes first; a request arriving in that
    // same cycle refills the slot that is being emptied.
    assign in_idle   = (state == ST_IDLE);
    assign take_pend = in_idle & pend_valid;
    assign take_new  = in_idle & ~pend_valid & ddr2_enable;
    assign dispatch  = take_pend | take_new;
    assign disp_read = take_pend ? pend_read : ddr2_read;
    assign disp_addr = take_pend ? pend_addr : ddr2_addr[ADDR_BITS-1:4];
    assign disp_data = take_pend ? pend_data : to_ddr2_data;

    assign pend_push = ddr2_enable & ~take_new & (~pend_valid | take_pend);
    assign drop      = ddr2_enable & pend_valid & ~take_pend;

    req_hold_buf u_hold (
        .clk       (clk),
        .rstn      (rstn),
        .push      (pend_push),
        .push_read (ddr2_read),
        .push_addr (ddr2_addr[ADDR_BITS-1:4]),
        .push_data (to_ddr2_data),
        .pop       (take_pend),
        .valid     (pend_valid),
        .read      (pend_read),
        .addr      (pend_addr),
        .data      (pend_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_overflow <= 1'b0;
        end else if (drop) begin
            req_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (dispatch) begin
            cur_addr <= disp_addr;
            cur_data <= disp_data;
        end
    end

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    assign beat_done = mem_en & mem_ready;
    assign last_beat = beat_done & (beat == BEAT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state)
            ST_IDLE: begin
                if (dispatch) begin
                    next_state = disp_read ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cur_addr, beat};
                mem_wdata = line_word(cur_data, beat);
                if (last_beat) begin
                    next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                mem_en   = 1'b1;
                mem_addr = {cur_addr, beat};
                if (last_beat) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                next_state = ST_RESP;
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Counter clears on the final beat so it never presents a fifth beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat <= '0;
        end else if (in_idle) begin
            beat <= '0;
        end else if (beat_done) begin
            beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // p1: read word returns one cycle after its beat was accepted
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= (state == ST_READ) & beat_done;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_READ) && beat_done) begin
            rd_idx_p1 <= beat;
        end
    end

    // Words 0..2 are staged here so the visible line only changes once the
    // whole read has arrived; word 3 goes straight into ddr2_data in DRAIN.
    always_ff @(posedge clk) begin
        if (rd_vld_p1 && (rd_idx_p1 != BEAT_W'(BEATS - 1))) begin
            shadow[rd_idx_p1] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ddr2_data <= '0;
        end else if (state == ST_DRAIN) begin
            ddr2_data <= {mem_rdata, shadow[2], shadow[1], shadow[0]};
        end
    end

    // Registered so the pulse lands in the cycle after RESP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ddr2_available <= 1'b0;
        end else begin
            ddr2_available <= (state == ST_RESP);
        end
    end

endmodule
